picorv32_mem_arbiter: RTL and testbench
=======================================

Name: picorv32_mem_arbiter

Overview:
- Shares one single-port synchronous SRAM between two requesters that use the PicoRV32 native memory handshake (valid/ready, addr, wdata, wstrb, rdata).
- Port m0 is the CPU. Port m1 is a loader or DMA agent.
- The block arbitrates between the ports with round-robin priority and sequences each SRAM access through a fixed multi-state FSM with optional wait states.
- It sits between picorv32 and the memory model or SRAM macro in the testbench and SoC top.

Parameters:
- ADDR_W, 32, byte-address width of both requester ports.
- DEPTH_WORDS, 1024, number of 32-bit words in the SRAM. Word addresses >= DEPTH_WORDS are out of range.
- WAIT_STATES, 0, extra SRAM cycles inserted after the enable cycle. Legal range 0..15.
- OOB_DATA, 32'hDEADBEEF, read data returned for out-of-range reads.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- m0_valid  in  1  CPU request valid.
- m0_ready  out  1  CPU transfer complete.
- m0_addr  in  ADDR_W  CPU byte address.
- m0_wdata  in  32  CPU write data.
- m0_wstrb  in  4  CPU byte strobes. 0 means read.
- m0_rdata  out  32  CPU read data.
- m1_valid, m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_rdata: same directions, widths and meanings as the m0 signals, for port m1.
- sram_en  out  1  SRAM access strobe.
- sram_we  out  4  SRAM byte write enables.
- sram_addr  out  ADDR_W-2  SRAM word address.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data, valid in the cycle after sram_en and held until the next sram_en.
- grant  out  2  one-hot owner of the current transaction. 00 when idle.
- oob_err  out  1  pulses together with ready when the transaction was out of range.

Behaviour:
- Reset (asynchronous, resetn low): state=IDLE, owner=0, last_owner=1, wait counter=0.
  - Latched addr, wdata and wstrb are 0. m0_rdata and m1_rdata are 0.
  - All ready signals, sram_en, sram_we, grant and oob_err are 0. Outputs take these values immediately, without waiting for a clock edge.
- FSM states: IDLE, ACCESS, WAIT, LATCH, RESP. All outputs are decoded from state plus registers; no input reaches an output combinationally.
- IDLE:
  - If no valid is high, stay in IDLE.
  - If exactly one valid is high, that port wins.
  - If both are high, the winner is the port that is not last_owner. Port m0 therefore wins the first tie after reset.
  - Latch the winner's addr, wdata and wstrb, and compute oob = (addr>>2) >= DEPTH_WORDS. Go to ACCESS.
- ACCESS (1 cycle):
  - If not oob: sram_en=1, sram_we=latched wstrb, sram_addr=latched addr[ADDR_W-1:2], sram_wdata=latched wdata.
  - If oob: sram_en=0 and sram_we=0.
  - Load the wait counter with WAIT_STATES. Go to WAIT if WAIT_STATES>0, otherwise go to LATCH.
- WAIT: sram_en=0. Decrement the counter each cycle. Leave for LATCH in the cycle the counter reaches 1, so WAIT lasts exactly WAIT_STATES cycles.
- LATCH (1 cycle), read transactions only (latched wstrb==0):
  - The owner's rdata register loads sram_rdata, or OOB_DATA if oob.
  - Writes leave rdata unchanged. The other port's rdata never changes.
- RESP (1 cycle): the owner's ready=1 and oob_err=oob. Set last_owner=owner. Valids are not sampled in this cycle. Go to IDLE.
- Latency: for a request first seen in IDLE at cycle N:
  - sram_en is high in N+1.
  - ready is high in exactly N+3+WAIT_STATES, for one cycle.
  - The next grant can occur no earlier than N+4+WAIT_STATES.
- Back-to-back: a requester that raises a new valid in the cycle after its ready is sampled in the following IDLE cycle.
- grant equals the one-hot owner in ACCESS, WAIT, LATCH and RESP.
- Requester protocol: valid and request fields must be held until ready. A request is never aborted. If valid drops mid-transaction, the transaction still completes and ready still pulses.
- Any change to a port's addr, wdata or wstrb after grant has no effect; the latched copies are used.
- The loser of a tie keeps waiting. It is guaranteed service in the next transaction, so a requester is served within at most one other transaction.

Test Plan:
- Single read, WAIT_STATES=0: bench SRAM word 5 = 32'h12345678; m0 read at 0x14 seen in cycle N.
  - Expect sram_en=1 and sram_addr=5 in N+1.
  - Expect m0_ready=1 and m0_rdata=32'h12345678 in N+3, grant=01.
  - Expect m1_ready to stay 0 throughout.
- Byte write: m1 writes addr 0x20, wdata 32'hAABBCCDD, wstrb 4'b0010.
  - Expect sram_we=0010 and sram_addr=8 for exactly one cycle (N+1), m1_ready in N+3.
  - Expect a readback of word 8 to show only byte 1 = 8'hCC changed.
- Tie after reset: m0 and m1 both valid in cycle N.
  - Expect m0_ready in N+3 and m1_ready in N+7.
  - A second simultaneous pair is served m0 first again (last_owner=1 after m1). Continuous m0+m1 requests alternate 0,1,0,1.
- WAIT_STATES=3 read: expect sram_en high only in N+1 and m0_ready in N+6 with correct data.
- Out of range, DEPTH_WORDS=1024: m0 read at 0x1000.
  - Expect sram_en to stay 0, m0_ready in N+3 with m0_rdata=32'hDEADBEEF and oob_err=1 in the same cycle.
- Reset mid-WAIT (WAIT_STATES=3): drive resetn low for 2 cycles during WAIT.
  - Expect ready, sram_en and grant to go to 0 immediately.
  - After release, a new m1 request completes normally with m1 winning only if m0 is idle.

Source files
------------

// File: rtl/picorv32_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : picorv32_mem_arbiter
// Brief   : Round-robin arbiter sharing one single-port synchronous SRAM
//           between two PicoRV32-native memory requesters.
// Revision: 1.0
// ============================================================================
module picorv32_mem_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] OOB_DATA    = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              m0_valid,
  output logic              m0_ready,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wstrb,
  output logic [31:0]       m0_rdata,

  input  logic              m1_valid,
  output logic              m1_ready,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic [31:0]       m1_rdata,

  output logic              sram_en,
  output logic [3:0]        sram_we,
  output logic [ADDR_W-3:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,

  output logic [1:0]        grant,
  output logic              oob_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCESS = 3'd1,
    S_WAIT   = 3'd2,
    S_LATCH  = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  // Byte-address limit; (addr>>2) >= DEPTH_WORDS is the same as addr >= 4*DEPTH_WORDS.
  localparam logic [ADDR_W:0] OOB_BASE  = (ADDR_W+1)'(DEPTH_WORDS) << 2;
  localparam logic [3:0]      WAIT_INIT = 4'(WAIT_STATES);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-3:0] word_q, word_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              oob_q, oob_d;
  logic [31:0]       m0_rdata_q, m0_rdata_d;
  logic [31:0]       m1_rdata_q, m1_rdata_d;

  logic              win;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [3:0]        sel_wstrb;
  logic [31:0]       rd_val;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      wait_cnt_q   <= 4'd0;
      word_q       <= '0;
      wdata_q      <= 32'd0;
      wstrb_q      <= 4'd0;
      oob_q        <= 1'b0;
      m0_rdata_q   <= 32'd0;
      m1_rdata_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      wait_cnt_q   <= wait_cnt_d;
      word_q       <= word_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      oob_q        <= oob_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    wait_cnt_d   = wait_cnt_q;
    word_d       = word_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    oob_d        = oob_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;

    // On a tie the port that did not own the previous transaction wins.
    win       = (m0_valid && m1_valid) ? ~last_owner_q : m1_valid;
    sel_addr  = win ? m1_addr  : m0_addr;
    sel_wdata = win ? m1_wdata : m0_wdata;
    sel_wstrb = win ? m1_wstrb : m0_wstrb;
    rd_val    = oob_q ? OOB_DATA : sram_rdata;

    case (state_q)
      S_IDLE: begin
        if (m0_valid || m1_valid) begin
          owner_d = win;
          word_d  = sel_addr[ADDR_W-1:2];
          wdata_d = sel_wdata;
          wstrb_d = sel_wstrb;
          oob_d   = ({1'b0, sel_addr} >= OOB_BASE);
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        wait_cnt_d = WAIT_INIT;
        state_d    = (WAIT_INIT != 4'd0) ? S_WAIT : S_LATCH;
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q - 4'd1;
        if (wait_cnt_q == 4'd1) begin
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        if (wstrb_q == 4'd0) begin
          if (owner_q) begin
            m1_rdata_d = rd_val;
          end else begin
            m0_rdata_d = rd_val;
          end
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        last_owner_d = owner_q;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign sram_en    = (state_q == S_ACCESS) && !oob_q;
  assign sram_we    = sram_en ? wstrb_q : 4'd0;
  assign sram_addr  = word_q;
  assign sram_wdata = wdata_q;
  assign grant      = (state_q == S_IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
  assign m0_ready   = (state_q == S_RESP) && !owner_q;
  assign m1_ready   = (state_q == S_RESP) && owner_q;
  assign oob_err    = (state_q == S_RESP) && oob_q;
  assign m0_rdata   = m0_rdata_q;
  assign m1_rdata   = m1_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_picorv32_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_picorv32_mem_arbiter
// Brief   : Two arbiter instances (0 and 3 wait states), one active at a time,
//           checked cycle by cycle against a transaction timeline model.
// Revision: 1.0
// ============================================================================
module tb_picorv32_mem_arbiter;

  localparam int DEPTH = 1024;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n_cmd;
  logic sel;
  logic resetn_a, resetn_b;
  assign resetn_a = sel ? 1'b0 : rst_n_cmd;
  assign resetn_b = sel ? rst_n_cmd : 1'b0;

  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] sram_rdata;

  logic        a_m0_ready, a_m1_ready, a_sram_en, a_oob_err;
  logic [31:0] a_m0_rdata, a_m1_rdata, a_sram_wdata;
  logic [3:0]  a_sram_we;
  logic [29:0] a_sram_addr;
  logic [1:0]  a_grant;
  logic        b_m0_ready, b_m1_ready, b_sram_en, b_oob_err;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_sram_wdata;
  logic [3:0]  b_sram_we;
  logic [29:0] b_sram_addr;
  logic [1:0]  b_grant;

  picorv32_mem_arbiter #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .OOB_DATA(32'hDEADBEEF)) u_dut_a (
    .clk(clk), .resetn(resetn_a),
    .m0_valid(m0_valid), .m0_ready(a_m0_ready), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_rdata(a_m0_rdata),
    .m1_valid(m1_valid), .m1_ready(a_m1_ready), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_rdata(a_m1_rdata),
    .sram_en(a_sram_en), .sram_we(a_sram_we), .sram_addr(a_sram_addr),
    .sram_wdata(a_sram_wdata), .sram_rdata(sram_rdata),
    .grant(a_grant), .oob_err(a_oob_err)
  );

  picorv32_mem_arbiter #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(3), .OOB_DATA(32'hDEADBEEF)) u_dut_b (
    .clk(clk), .resetn(resetn_b),
    .m0_valid(m0_valid), .m0_ready(b_m0_ready), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_rdata(b_m0_rdata),
    .m1_valid(m1_valid), .m1_ready(b_m1_ready), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_rdata(b_m1_rdata),
    .sram_en(b_sram_en), .sram_we(b_sram_we), .sram_addr(b_sram_addr),
    .sram_wdata(b_sram_wdata), .sram_rdata(sram_rdata),
    .grant(b_grant), .oob_err(b_oob_err)
  );

  logic        o_m0_ready, o_m1_ready, o_sram_en, o_oob_err;
  logic [31:0] o_m0_rdata, o_m1_rdata, o_sram_wdata;
  logic [3:0]  o_sram_we;
  logic [29:0] o_sram_addr;
  logic [1:0]  o_grant;
  assign o_m0_ready   = sel ? b_m0_ready   : a_m0_ready;
  assign o_m1_ready   = sel ? b_m1_ready   : a_m1_ready;
  assign o_sram_en    = sel ? b_sram_en    : a_sram_en;
  assign o_oob_err    = sel ? b_oob_err    : a_oob_err;
  assign o_m0_rdata   = sel ? b_m0_rdata   : a_m0_rdata;
  assign o_m1_rdata   = sel ? b_m1_rdata   : a_m1_rdata;
  assign o_sram_wdata = sel ? b_sram_wdata : a_sram_wdata;
  assign o_sram_we    = sel ? b_sram_we    : a_sram_we;
  assign o_sram_addr  = sel ? b_sram_addr  : a_sram_addr;
  assign o_grant      = sel ? b_grant      : a_grant;

  // Bench-side SRAM: one port, read data appears the cycle after the enable.
  logic [31:0] sram_mem [0:DEPTH-1];
  logic        pre_en;
  logic [9:0]  pre_idx;
  logic [31:0] pre_data;
  always @(posedge clk) begin
    if (pre_en) begin
      sram_mem[pre_idx] <= pre_data;
    end else if (o_sram_en) begin
      for (int b = 0; b < 4; b++) begin
        if (o_sram_we[b]) sram_mem[o_sram_addr[9:0]][8*b +: 8] <= o_sram_wdata[8*b +: 8];
      end
      sram_rdata <= sram_mem[o_sram_addr[9:0]];
    end
  end

  // Reference state: memory contents, per-port read data, last served port.
  logic [31:0] model_mem [0:DEPTH-1];
  logic [31:0] exp_rd [2];
  int          model_last;
  int          pass_cnt;
  int          total_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input int p, input bit v, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    if (p == 0) begin
      m0_valid = v; m0_addr = a; m0_wdata = d; m0_wstrb = s;
    end else begin
      m1_valid = v; m1_addr = a; m1_wdata = d; m1_wstrb = s;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, ".m0_ready"}, 32'(o_m0_ready), 32'd0);
    chk({tag, ".m1_ready"}, 32'(o_m1_ready), 32'd0);
    chk({tag, ".sram_en"},  32'(o_sram_en), 32'd0);
    chk({tag, ".sram_we"},  32'(o_sram_we), 32'd0);
    chk({tag, ".grant"},    32'(o_grant), 32'd0);
    chk({tag, ".oob_err"},  32'(o_oob_err), 32'd0);
    chk({tag, ".m0_rdata"}, o_m0_rdata, 32'd0);
    chk({tag, ".m1_rdata"}, o_m1_rdata, 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return $urandom | 32'h8000_0000;
    if (r == 1) return 32'(DEPTH * 4) + 32'($urandom_range(0, 63));
    return (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  // One request (or a simultaneous pair), checked every cycle against the
  // timeline: IDLE sample at s, enable at s+1, ready at s+3+ws, next IDLE at s+4+ws.
  task automatic run_txn(input bit v0, input bit v1,
                         input logic [31:0] a0, input logic [31:0] d0, input logic [3:0] s0,
                         input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] s1,
                         input bit mess);
    int          ws, n, p, w, last_c;
    int          t_own[2], t_start[2];
    bit          t_in[2];
    logic [3:0]  t_strb[2];
    logic [29:0] t_word[2];
    logic [31:0] t_wd[2], t_rd[2], addr;
    bit          e_en, e_rdy0, e_rdy1, e_oob;
    logic [3:0]  e_we;
    logic [1:0]  e_gr;
    logic [29:0] e_word;
    logic [31:0] e_wd;

    ws = sel ? 3 : 0;
    n  = (v0 && v1) ? 2 : 1;
    if (n == 2) begin
      t_own[0] = 1 - model_last;
      t_own[1] = model_last;
    end else begin
      t_own[0] = v1 ? 1 : 0;
      t_own[1] = 0;
    end
    for (int i = 0; i < n; i++) begin
      p          = t_own[i];
      addr       = p ? a1 : a0;
      t_strb[i]  = p ? s1 : s0;
      t_wd[i]    = p ? d1 : d0;
      t_start[i] = i * (4 + ws);
      t_word[i]  = addr[31:2];
      t_in[i]    = (addr >> 2) < 32'(DEPTH);
      t_rd[i]    = 32'd0;
      w          = int'(addr[11:2]);
      if (t_strb[i] == 4'd0) begin
        t_rd[i] = t_in[i] ? model_mem[w] : 32'hDEADBEEF;
      end else if (t_in[i]) begin
        for (int b = 0; b < 4; b++) begin
          if (t_strb[i][b]) model_mem[w][8*b +: 8] = t_wd[i][8*b +: 8];
        end
      end
      model_last = p;
    end

    @(negedge clk);
    drive(0, v0, a0, d0, s0);
    drive(1, v1, a1, d1, s1);
    last_c = t_start[n-1] + 4 + ws;
    for (int c = 1; c <= last_c; c++) begin
      @(posedge clk);
      #1;
      e_en = 1'b0; e_we = 4'd0; e_gr = 2'b00; e_rdy0 = 1'b0; e_rdy1 = 1'b0; e_oob = 1'b0;
      e_word = '0; e_wd = 32'd0;
      for (int i = 0; i < n; i++) begin
        if (c == t_start[i] + 1 && t_in[i]) begin
          e_en = 1'b1; e_we = t_strb[i]; e_word = t_word[i]; e_wd = t_wd[i];
        end
        if (c >= t_start[i] + 1 && c <= t_start[i] + 3 + ws)
          e_gr = (t_own[i] == 1) ? 2'b10 : 2'b01;
        if (c == t_start[i] + 3 + ws) begin
          if (t_own[i] == 1) e_rdy1 = 1'b1; else e_rdy0 = 1'b1;
          e_oob = !t_in[i];
          if (t_strb[i] == 4'd0) exp_rd[t_own[i]] = t_rd[i];
        end
      end
      chk("sram_en",  32'(o_sram_en), 32'(e_en));
      chk("sram_we",  32'(o_sram_we), 32'(e_we));
      chk("grant",    32'(o_grant), 32'(e_gr));
      chk("m0_ready", 32'(o_m0_ready), 32'(e_rdy0));
      chk("m1_ready", 32'(o_m1_ready), 32'(e_rdy1));
      chk("oob_err",  32'(o_oob_err), 32'(e_oob));
      chk("m0_rdata", o_m0_rdata, exp_rd[0]);
      chk("m1_rdata", o_m1_rdata, exp_rd[1]);
      if (e_en) begin
        chk("sram_addr",  32'(o_sram_addr), 32'(e_word));
        chk("sram_wdata", o_sram_wdata, e_wd);
      end
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
        if (c == t_start[i] + 3 + ws)
          drive(t_own[i], 1'b0, $urandom, $urandom, 4'($urandom));
        else if (mess && c >= t_start[i] + 1 && c < t_start[i] + 3 + ws)
          drive(t_own[i], 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
      end
    end
  endtask

  task automatic phase_reset(input bit which);
    @(negedge clk);
    rst_n_cmd = 1'b0;
    sel       = which;
    drive(0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(1, 1'b0, 32'd0, 32'd0, 4'd0);
    #1;
    check_idle_outputs(which ? "rst_b" : "rst_a");
    @(negedge clk);
    @(negedge clk);
    rst_n_cmd  = 1'b1;
    exp_rd[0]  = 32'd0;
    exp_rd[1]  = 32'd0;
    model_last = 1;
  endtask

  task automatic random_txns(input int count);
    int          pat;
    logic [31:0] a0, a1;
    logic [3:0]  s0, s1;
    for (int k = 0; k < count; k++) begin
      pat = $urandom_range(1, 3);
      a0  = rand_addr();
      a1  = rand_addr();
      s0  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
      s1  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
      run_txn(pat[0], pat[1], a0, $urandom, s0, a1, $urandom, s1, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    logic [31:0] d;
    pass_cnt  = 0;
    total_cnt = 0;
    pre_en    = 1'b0;
    pre_idx   = 10'd0;
    pre_data  = 32'd0;
    sel       = 1'b0;
    rst_n_cmd = 1'b1;
    drive(0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(1, 1'b0, 32'd0, 32'd0, 4'd0);
    #2;
    rst_n_cmd = 1'b0;
    #1;
    check_idle_outputs("por");

    for (int i = 0; i < DEPTH; i++) begin
      d = (i == 5) ? 32'h12345678 : $urandom;
      model_mem[i] = d;
      @(negedge clk);
      pre_en   = 1'b1;
      pre_idx  = 10'(i);
      pre_data = d;
    end
    @(negedge clk);
    pre_en = 1'b0;

    // Zero wait states.
    phase_reset(1'b0);
    run_txn(1, 0, 32'h14, 32'd0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b0);
    chk("read_w5", o_m0_rdata, 32'h12345678);
    run_txn(0, 1, 32'd0, 32'd0, 4'd0, 32'h20, 32'hAABBCCDD, 4'b0010, 1'b0);
    run_txn(1, 0, 32'h20, 32'd0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b0);
    run_txn(1, 1, 32'h14, 32'd0, 4'd0, 32'h20, 32'd0, 4'd0, 1'b0);
    run_txn(1, 1, 32'h24, 32'd0, 4'd0, 32'h28, 32'd0, 4'd0, 1'b0);
    run_txn(0, 1, 32'd0, 32'd0, 4'd0, 32'hFFC, 32'd0, 4'd0, 1'b0);
    run_txn(1, 0, 32'h1000, 32'd0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b0);
    chk("oob_rdata", o_m0_rdata, 32'hDEADBEEF);
    run_txn(0, 1, 32'd0, 32'd0, 4'd0, 32'h4000_0000, 32'h0BAD_F00D, 4'hF, 1'b0);
    run_txn(1, 1, 32'h30, 32'h1111_2222, 4'hF, 32'h30, 32'h3333_4444, 4'b1100, 1'b1);
    random_txns(40);

    // Three wait states.
    phase_reset(1'b1);
    run_txn(1, 0, 32'h14, 32'd0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b0);
    run_txn(1, 1, 32'h1000, 32'd0, 4'd0, 32'h40, 32'h5566_7788, 4'b1001, 1'b0);
    random_txns(15);

    // Reset asserted while the first wait cycle is in progress.
    @(negedge clk);
    drive(0, 1'b1, 32'h14, 32'd0, 4'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("pre_rst_grant", 32'(o_grant), 32'd1);
    #2;
    rst_n_cmd = 1'b0;
    #1;
    check_idle_outputs("mid_wait_rst");
    drive(0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_idle_outputs("held_rst");
    @(negedge clk);
    rst_n_cmd  = 1'b1;
    exp_rd[0]  = 32'd0;
    exp_rd[1]  = 32'd0;
    model_last = 1;
    run_txn(0, 1, 32'd0, 32'd0, 4'd0, 32'h14, 32'd0, 4'd0, 1'b0);
    run_txn(1, 1, 32'h20, 32'd0, 4'd0, 32'h24, 32'd0, 4'd0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
